// File: rtl/seq_det_sched.sv
// Sequencing controller for the serial 1010 Moore detector: serialises framed
// words MSB first, clears the detector per frame, and tallies its matches.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for the first word of a frame, in_ready high
// S_RST_DET | one cycle of det_rst so the detector starts the frame clean
// S_SHIFT   | one bit per cycle to the detector, next word buffered ahead
// S_DRAIN   | no new bit; sample the detector's answer to the final bit
// S_DONE    | one-cycle done pulse, results held until the next frame
module seq_det_sched #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              det_rst,
  output logic              det_bit,
  input  logic              det_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  match_count,
  output logic [IDX_W-1:0]  last_match_idx
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_TOP = BC_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_DET,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              last_cur_q, last_cur_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic [BC_W-1:0]   bit_left_q, bit_left_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              bit_vld_q, bit_vld_d;
  logic              det_rst_q, det_rst_d;
  logic              det_bit_q, det_bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_q, err_d;
  logic              hs;

  // Once the last word is shifting or buffered, nothing more belongs to this frame.
  assign in_ready = !reset &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_SHIFT) && !hold_full_q && !last_cur_q));
  assign hs = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    last_cur_d  = last_cur_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    bit_left_d  = bit_left_q;
    bit_idx_d   = bit_idx_q;
    bit_vld_d   = 1'b0;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          sr_d        = in_data;
          last_cur_d  = in_last;
          hold_full_d = 1'b0;
          bit_left_d  = BC_TOP;
          bit_idx_d   = '0;
          cnt_d       = '0;
          idx_d       = '0;
          err_d       = 1'b0;
          state_d     = S_RST_DET;
        end
      end
      S_RST_DET: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bit_vld_d = 1'b1;
        bit_idx_d = bit_idx_q + IDX_W'(1);
        if (bit_left_q != '0) begin
          sr_d       = {sr_q[WORD_W-2:0], 1'b0};
          bit_left_d = bit_left_q - BC_W'(1);
          if (hs) begin
            hold_data_d = in_data;
            hold_last_d = in_last;
            hold_full_d = 1'b1;
          end
        end else begin
          bit_left_d = BC_TOP;
          if (hold_full_q) begin
            sr_d        = hold_data_q;
            last_cur_d  = hold_last_q;
            hold_full_d = 1'b0;
          end else if (last_cur_q) begin
            state_d = S_DRAIN;
          end else if (hs) begin
            // Word arriving on the final-bit cycle goes straight to the shifter.
            sr_d       = in_data;
            last_cur_d = in_last;
          end else begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // det_out answers the bit shown last cycle, whose index is one behind.
    if (bit_vld_q && det_out) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      idx_d = bit_idx_q - IDX_W'(1);
    end
  end

  assign det_rst_d = (state_d == S_RST_DET);
  assign det_bit_d = (state_d == S_SHIFT) ? sr_d[WORD_W-1] : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      last_cur_q  <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      bit_left_q  <= '0;
      bit_idx_q   <= '0;
      bit_vld_q   <= 1'b0;
      det_rst_q   <= 1'b1;
      det_bit_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      last_cur_q  <= last_cur_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      bit_left_q  <= bit_left_d;
      bit_idx_q   <= bit_idx_d;
      bit_vld_q   <= bit_vld_d;
      det_rst_q   <= det_rst_d;
      det_bit_q   <= det_bit_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  end

  assign det_rst        = det_rst_q;
  assign det_bit        = det_bit_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign match_count    = cnt_q;
  assign last_match_idx = idx_q;

endmodule
